// File: rtl/ctrl_status_regs_n_if.sv
// Host-side register bus shared by the register block and its adapter.
// The master drives address, strobes and write data; the slave returns read data.
interface ctrl_status_regs_n_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 4
) ();
    logic [AWIDTH-1:0]   addr;
    logic                wr_en;
    logic [DWIDTH/8-1:0] wr_be;
    logic [DWIDTH-1:0]   data_in;
    logic                rd_en;
    logic [DWIDTH-1:0]   data_out;
    logic                rd_valid;

    modport master (
        output addr, wr_en, wr_be, data_in, rd_en,
        input  data_out, rd_valid
    );

    modport slave (
        input  addr, wr_en, wr_be, data_in, rd_en,
        output data_out, rd_valid
    );
endinterface

// File: rtl/ctrl_status_regs_n.sv
// NREGS control/status register pairs with byte-enable writes, write-notify pulses,
// a registered read path and a sticky W1C interrupt block with mask and level irq.
module ctrl_status_regs_n #(
    parameter int DWIDTH = 32,
    parameter int NREGS  = 8,
    parameter int AWIDTH = 4,
    parameter int EWIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    ctrl_status_regs_n_if.slave     bus,
    output logic [NREGS*DWIDTH-1:0] ctrl_flat,
    output logic [NREGS-1:0]        ctrl_wr_pulse,
    input  logic [NREGS*DWIDTH-1:0] status_flat,
    input  logic [EWIDTH-1:0]       event_in,
    output logic                    irq
);

    localparam int NBYTES = DWIDTH / 8;
    localparam logic [AWIDTH-1:0] ADDR_IRQ_STATUS = AWIDTH'(NREGS);
    localparam logic [AWIDTH-1:0] ADDR_IRQ_MASK   = AWIDTH'(NREGS + 1);

    // Expand byte enables into a per-bit mask.
    function automatic logic [DWIDTH-1:0] lane_mask(input logic [NBYTES-1:0] be);
        logic [DWIDTH-1:0] m;
        m = '0;
        for (int k = 0; k < NBYTES; k++) begin
            m[8*k +: 8] = {8{be[k]}};
        end
        return m;
    endfunction

    logic [NREGS-1:0][DWIDTH-1:0] ctrl_r;
    logic [NREGS-1:0]             ctrl_wr_pulse_r;
    logic [DWIDTH-1:0]            data_out_r;
    logic                         rd_valid_r;
    logic [EWIDTH-1:0]            irq_status_r;
    logic [EWIDTH-1:0]            irq_mask_r;
    logic                         irq_r;

    logic [DWIDTH-1:0]            be_mask_s;
    logic [NREGS-1:0]             ctrl_sel_s;
    logic [NREGS-1:0]             ctrl_we_s;
    logic                         stat_sel_s;
    logic                         mask_sel_s;
    logic [EWIDTH-1:0]            w1c_clear_s;
    logic [EWIDTH-1:0]            irq_status_next_s;
    logic [EWIDTH-1:0]            irq_mask_next_s;
    logic [DWIDTH-1:0]            rd_mux_s;

    // Full-width address decode and byte-lane masks for the write path.
    always_comb begin
        be_mask_s  = lane_mask(bus.wr_be);
        ctrl_sel_s = '0;
        for (int i = 0; i < NREGS; i++) begin
            ctrl_sel_s[i] = (bus.addr == AWIDTH'(i));
        end
        stat_sel_s = (bus.addr == ADDR_IRQ_STATUS);
        mask_sel_s = (bus.addr == ADDR_IRQ_MASK);
        ctrl_we_s  = ctrl_sel_s & {NREGS{bus.wr_en}};
    end

    // Next-state of the interrupt registers; an event in the same cycle beats a clear.
    always_comb begin
        w1c_clear_s = '0;
        if (bus.wr_en && stat_sel_s) begin
            w1c_clear_s = bus.data_in[EWIDTH-1:0] & be_mask_s[EWIDTH-1:0];
        end else begin
            w1c_clear_s = '0;
        end
        irq_mask_next_s = irq_mask_r;
        if (bus.wr_en && mask_sel_s) begin
            irq_mask_next_s = (irq_mask_r & ~be_mask_s[EWIDTH-1:0])
                            | (bus.data_in[EWIDTH-1:0] & be_mask_s[EWIDTH-1:0]);
        end else begin
            irq_mask_next_s = irq_mask_r;
        end
        irq_status_next_s = (irq_status_r & ~w1c_clear_s) | event_in;
    end

    // Read mux: selects are one-hot, so an AND-OR tree yields 0 for unmapped addresses.
    always_comb begin
        rd_mux_s = '0;
        for (int i = 0; i < NREGS; i++) begin
            rd_mux_s = rd_mux_s | (status_flat[i*DWIDTH +: DWIDTH] & {DWIDTH{ctrl_sel_s[i]}});
        end
        rd_mux_s = rd_mux_s | (DWIDTH'(irq_status_r) & {DWIDTH{stat_sel_s}});
        rd_mux_s = rd_mux_s | (DWIDTH'(irq_mask_r)   & {DWIDTH{mask_sel_s}});
    end

    // Control registers and their one-cycle write-notify pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_r          <= '0;
            ctrl_wr_pulse_r <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (ctrl_we_s[i]) begin
                    ctrl_r[i] <= (ctrl_r[i] & ~be_mask_s) | (bus.data_in & be_mask_s);
                end
            end
            ctrl_wr_pulse_r <= ctrl_we_s;
        end
    end

    // Registered read path; data_out holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_r <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= bus.rd_en;
            if (bus.rd_en) begin
                data_out_r <= rd_mux_s;
            end
        end
    end

    // Sticky status, mask and the registered level interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_status_r <= '0;
            irq_mask_r   <= '0;
            irq_r        <= 1'b0;
        end else begin
            irq_status_r <= irq_status_next_s;
            irq_mask_r   <= irq_mask_next_s;
            irq_r        <= |(irq_status_r & irq_mask_r);
        end
    end

    assign ctrl_flat     = ctrl_r;
    assign ctrl_wr_pulse = ctrl_wr_pulse_r;
    assign bus.data_out  = data_out_r;
    assign bus.rd_valid  = rd_valid_r;
    assign irq           = irq_r;

endmodule

// File: tb/tb_ctrl_status_regs_n.sv
// Scoreboard bench for ctrl_status_regs_n: reads push expected data, a monitor pops on rd_valid.
module tb_ctrl_status_regs_n;
    localparam int DWIDTH = 32;
    localparam int NREGS  = 8;
    localparam int AWIDTH = 4;
    localparam int EWIDTH = 8;
    localparam logic [3:0] A_STAT = 4'd8;
    localparam logic [3:0] A_MASK = 4'd9;

    logic                    clk;
    logic                    reset;
    logic [NREGS*DWIDTH-1:0] ctrl_flat;
    logic [NREGS-1:0]        ctrl_wr_pulse;
    logic [NREGS*DWIDTH-1:0] status_flat;
    logic [EWIDTH-1:0]       event_in;
    logic                    irq;

    ctrl_status_regs_n_if #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) bif ();

    ctrl_status_regs_n #(.DWIDTH(DWIDTH), .NREGS(NREGS), .AWIDTH(AWIDTH), .EWIDTH(EWIDTH)) dut (
        .clk(clk), .reset(reset), .bus(bif),
        .ctrl_flat(ctrl_flat), .ctrl_wr_pulse(ctrl_wr_pulse),
        .status_flat(status_flat), .event_in(event_in), .irq(irq)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] rd_q[$];
    logic        mon_en = 1'b0;
    logic        exp_rdv = 1'b0;
    logic [7:0]  exp_pulse = 8'h00;
    logic [255:0] exp_flat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected rd_valid and pulse derived from the inputs seen at each edge.
    always @(posedge clk) begin
        exp_rdv <= bif.rd_en && !reset;
        if (!reset && bif.wr_en && (bif.addr < 4'd8)) exp_pulse <= 8'h01 << bif.addr;
        else exp_pulse <= 8'h00;
    end

    // Monitor: compares rd_valid, pops the scoreboard on every valid read, checks pulses.
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if (bif.rd_valid !== exp_rdv) begin
                n_errors++;
                $display("FAIL rd_valid: got %b expected %b at %0t", bif.rd_valid, exp_rdv, $time);
            end
            if (bif.rd_valid === 1'b1) begin
                n_checks++;
                if (rd_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL rd_unexpected: got data %h with no read pending", bif.data_out);
                end else begin
                    logic [31:0] e;
                    e = rd_q.pop_front();
                    if (bif.data_out !== e) begin
                        n_errors++;
                        $display("FAIL rd_data: got %h expected %h at %0t", bif.data_out, e, $time);
                    end
                end
            end
            n_checks++;
            if (ctrl_wr_pulse !== exp_pulse) begin
                n_errors++;
                $display("FAIL wr_pulse: got %b expected %b at %0t", ctrl_wr_pulse, exp_pulse, $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        bif.addr = a; bif.data_in = d; bif.wr_be = be; bif.wr_en = 1'b1;
        tick();
        bif.wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a, input logic [31:0] e);
        bif.addr = a; bif.rd_en = 1'b1;
        rd_q.push_back(e);
        tick();
        bif.rd_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; event_in = 8'h00;
        bif.addr = 4'd0; bif.wr_en = 1'b0; bif.wr_be = 4'h0; bif.data_in = 32'h0; bif.rd_en = 1'b0;
        for (int i = 0; i < NREGS; i++) status_flat[i*32 +: 32] = 32'h000000A0 + 32'(i);
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_ctrl", 256'(ctrl_flat), 256'h0);
        chk("reset_irq", 256'(irq), 256'h0);
        chk("reset_dout", 256'(bif.data_out), 256'h0);
        mon_en = 1'b1;

        // Read the whole address space.
        for (int i = 0; i < 16; i++) begin
            do_read(4'(i), (i < NREGS) ? 32'h000000A0 + 32'(i) : 32'h0);
        end

        // Byte-lane writes to ctrl 3.
        do_write(4'd3, 32'hDEADBEEF, 4'b1111);
        do_write(4'd3, 32'h11223344, 4'b0101);
        @(negedge clk);
        exp_flat = 256'h0; exp_flat[96 +: 32] = 32'hDE22BE44;
        chk("ctrl3_be", 256'(ctrl_flat), exp_flat);

        // Masked event, then unmask, then W1C.
        event_in = 8'h05; tick(); event_in = 8'h00; tick();
        do_read(A_STAT, 32'h05);
        @(negedge clk); chk("irq_masked", 256'(irq), 256'h0);
        do_write(A_MASK, 32'h04, 4'hF);
        @(negedge clk); chk("irq_before_rise", 256'(irq), 256'h0);
        tick();
        @(negedge clk); chk("irq_rise", 256'(irq), 256'h1);
        do_write(A_STAT, 32'h04, 4'h1);
        @(negedge clk); chk("irq_before_fall", 256'(irq), 256'h1);
        tick();
        @(negedge clk); chk("irq_fall", 256'(irq), 256'h0);
        do_read(A_STAT, 32'h01);

        // Event and W1C on the same bit in the same cycle: set wins.
        event_in = 8'h04; tick(); event_in = 8'h00; tick();
        @(negedge clk); chk("irq_rearm", 256'(irq), 256'h1);
        event_in = 8'h04;
        do_write(A_STAT, 32'h04, 4'h1);
        event_in = 8'h00;
        @(negedge clk); chk("irq_hold0", 256'(irq), 256'h1);
        tick();
        @(negedge clk); chk("irq_hold1", 256'(irq), 256'h1);
        do_read(A_STAT, 32'h05);

        // Read and write of the mask in the same cycle returns the old mask.
        bif.rd_en = 1'b1; rd_q.push_back(32'h04);
        do_write(A_MASK, 32'hFFFFFF0F, 4'hF);
        bif.rd_en = 1'b0;
        do_read(A_MASK, 32'h0F);

        // Unused address: no effect, reads 0.
        do_write(4'd12, 32'hFFFFFFFF, 4'hF);
        @(negedge clk); chk("unused_wr", 256'(ctrl_flat), exp_flat);
        do_read(4'd12, 32'h0);

        // Reset mid-stream with a pending read and all sticky bits set.
        event_in = 8'hFF; tick(); event_in = 8'h00;
        do_write(4'd0, 32'hCAFEF00D, 4'hF);
        do_read(4'd0, 32'hA0);
        reset = 1'b1; bif.rd_en = 1'b1; bif.addr = 4'd1; bif.wr_en = 1'b1;
        bif.data_in = 32'h55555555; bif.wr_be = 4'hF; event_in = 8'h01;
        tick();
        reset = 1'b0; bif.rd_en = 1'b0; bif.wr_en = 1'b0; event_in = 8'h00;
        @(negedge clk);
        chk("rst_ctrl", 256'(ctrl_flat), 256'h0);
        chk("rst_dout", 256'(bif.data_out), 256'h0);
        chk("rst_irq", 256'(irq), 256'h0);
        do_write(4'd1, 32'h12345678, 4'hF);
        @(negedge clk);
        exp_flat = 256'h0; exp_flat[32 +: 32] = 32'h12345678;
        chk("post_rst_wr", 256'(ctrl_flat), exp_flat);
        do_read(A_STAT, 32'h0);
        do_read(A_MASK, 32'h0);
        do_read(4'd1, 32'hA1);

        tick(); tick();
        chk("scoreboard_empty", 256'(rd_q.size()), 256'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ctrl_status_regs_n.md
Name: ctrl_status_regs_n

Overview:
Parametrised successor to the 4-entry control/status register block. It provides NREGS control registers with byte-enable writes, NREGS status read-back words, and a registered read path with a valid strobe. It adds per-register write-notify pulses and a sticky, write-1-to-clear interrupt block with a mask and a level irq output. It sits between the host-side register bus adapter and the datapath blocks it configures and monitors.

Parameters:
DWIDTH, 32, data width; must be a multiple of 8
NREGS, 8, number of ctrl/status register pairs (1..2**AWIDTH-2)
AWIDTH, 4, address width; 2**AWIDTH >= NREGS+2
EWIDTH, 8, number of event inputs (1..DWIDTH)

Ports:
clk  in  1  single clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
addr  in  AWIDTH  word address for both reads and writes
wr_en  in  1  write strobe, single cycle
wr_be  in  DWIDTH/8  byte enables for writes; bit k covers data_in[8k+7:8k]
data_in  in  DWIDTH  write data
rd_en  in  1  read request
data_out  out  DWIDTH  registered read data
rd_valid  out  1  data_out valid; asserted exactly one cycle after rd_en
ctrl_flat  out  NREGS*DWIDTH  control registers; reg i is at [i*DWIDTH +: DWIDTH]
ctrl_wr_pulse  out  NREGS  bit i pulses for one cycle after any write to ctrl i
status_flat  in  NREGS*DWIDTH  status words; word i is at [i*DWIDTH +: DWIDTH]
event_in  in  EWIDTH  event pulses; each asserted cycle sets the matching sticky bit
irq  out  1  registered level interrupt = |(irq_status & irq_mask)

Behaviour:
Address map:
- 0..NREGS-1: write to ctrl i; read returns status i.
- NREGS: IRQ_STATUS. Read returns the sticky bits zero-extended to DWIDTH. Writing 1 clears a bit (W1C), gated by wr_be.
- NREGS+1: IRQ_MASK. Read/write, EWIDTH bits, upper bits read 0.
- Any higher address: writes are ignored; reads return 0 with rd_valid still asserted.

Reset (reset=1 at a clock edge):
- ctrl_flat, ctrl_wr_pulse, data_out, rd_valid, irq_status, irq_mask and irq all go to 0.
- Reset overrides any same-cycle write, read or event.
- A read issued in the reset cycle yields no rd_valid.

Writes:
- Byte lanes with wr_be=0 keep their old value.
- The write is visible on ctrl_flat the cycle after wr_en.
- ctrl_wr_pulse[i] is high in that same cycle, for exactly one cycle, even if all wr_be are 0.
- Back-to-back writes to the same register produce a pulse in each following cycle.

Reads:
- On a cycle with rd_en=1, data_out captures the mux value; rd_valid=1 in the next cycle.
- With rd_en=0, data_out holds its last value and rd_valid=0.
- A read and a write in the same cycle are both performed. The read returns the pre-write value of IRQ_STATUS or IRQ_MASK.
- Status words are sampled at the rd_en edge; no synchronisation is done in this block.

Events and interrupt:
- Each cycle, irq_status <= (irq_status & ~w1c_clear) | event_in.
- If an event and a W1C clear hit the same bit in the same cycle, the set wins (no event lost).
- irq is registered: it rises one cycle after the sticky bit or mask bit becomes 1, and falls one cycle after the clear or mask takes effect.
- Masked events still set irq_status.

Width rules:
- Byte enables map to IRQ regs lane-wise; bits at EWIDTH and above are ignored.
- Address compare is done at full AWIDTH; no aliasing.

Test Plan:
- Reset, then read all addresses 0..2**AWIDTH-1 with status i = 0xA0+i -> data_out = 0xA0+i for i<8, 0 for IRQ_STATUS, IRQ_MASK and unused addresses; each rd_valid exactly one cycle after rd_en.
- Write 0xDEADBEEF to addr 3 with wr_be=4'b1111, then 0x11223344 with wr_be=4'b0101 -> ctrl 3 = 0xDE22BE44. ctrl_wr_pulse[3] high one cycle after each write and in no other cycle. Other ctrl regs stay 0.
- Pulse event_in=0x05 with mask=0 -> IRQ_STATUS reads 0x05 and irq stays 0. Write IRQ_MASK=0x04 -> irq=1 one cycle later. W1C 0x04 -> irq falls one cycle later and IRQ_STATUS reads 0x01.
- event_in[2]=1 in the same cycle as a W1C of bit 2 -> bit 2 remains 1 and irq stays asserted.
- Write to addr 12 (unused) -> no ctrl change, no ctrl_wr_pulse, read returns 0.
- Assert reset mid-stream, with a pending read and IRQ_STATUS=0xFF -> next cycle all outputs are 0 and rd_valid=0. Normal writes work the cycle after reset is released.
